// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter for clear/raster/simd pixels; clips to viewport and framebuffer bounds.
// One-cycle latency to the registered fb write port; grants stall while a held write waits on fb_ready.
module pixel_write_arbiter #(
  parameter int NREQ      = 3,
  parameter int COORD_W   = 16,
  parameter int COLOR_W   = 24,
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480,
  parameter int ADDR_W    = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COORD_W-1:0]       vp_x0,
  input  logic [COORD_W-1:0]       vp_y0,
  input  logic [COORD_W-1:0]       vp_x1,
  input  logic [COORD_W-1:0]       vp_y1,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*COORD_W-1:0]  req_x,
  input  logic [NREQ*COORD_W-1:0]  req_y,
  input  logic [NREQ*COLOR_W-1:0]  req_color,
  output logic                     fb_valid,
  input  logic                     fb_ready,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic [COLOR_W-1:0]       fb_data,
  output logic                     busy,
  output logic [15:0]              clip_count,
  output logic [31:0]              write_count
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               fb_valid_q, fb_valid_d;
  logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0] fb_data_q, fb_data_d;
  logic [15:0]        clip_count_q, clip_count_d;
  logic [31:0]        write_count_q, write_count_d;

  logic               can_accept;
  logic               drain;
  logic               xfer;
  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   cand;
  logic [COORD_W-1:0] sel_x, sel_y;
  logic [COLOR_W-1:0] sel_color;
  logic               keep;

  assign can_accept = !fb_valid_q || fb_ready;
  assign drain      = fb_valid_q && fb_ready;

  // Search starts one past the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (can_accept && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign xfer      = can_accept && grant_found;
  assign sel_x     = req_x[int'(grant_idx)*COORD_W +: COORD_W];
  assign sel_y     = req_y[int'(grant_idx)*COORD_W +: COORD_W];
  assign sel_color = req_color[int'(grant_idx)*COLOR_W +: COLOR_W];

  // An inverted viewport fails one of the range tests and so clips everything.
  assign keep = (sel_x >= vp_x0) && (sel_x <= vp_x1) &&
                (sel_y >= vp_y0) && (sel_y <= vp_y1) &&
                (int'(sel_x) < FB_WIDTH) && (int'(sel_y) < FB_HEIGHT);

  always_comb begin
    ptr_d         = ptr_q;
    fb_valid_d    = fb_valid_q;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    clip_count_d  = clip_count_q;
    write_count_d = write_count_q;

    if (drain) begin
      fb_valid_d    = 1'b0;
      write_count_d = write_count_q + 32'd1;
    end

    if (xfer) begin
      ptr_d = grant_idx;
      if (keep) begin
        fb_valid_d = 1'b1;
        fb_addr_d  = ADDR_W'(64'(sel_y) * 64'(FB_WIDTH) + 64'(sel_x));
        fb_data_d  = sel_color;
      end else if (clip_count_q != 16'hFFFF) begin
        clip_count_d = clip_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= PTR_W'(NREQ - 1);
      fb_valid_q    <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      clip_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      fb_valid_q    <= fb_valid_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      clip_count_q  <= clip_count_d;
      write_count_q <= write_count_d;
    end
  end

  assign fb_valid    = fb_valid_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign clip_count  = clip_count_q;
  assign write_count = write_count_q;
  assign busy        = fb_valid_q || (|req_valid);

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: directed vector table, hand sequences, and random traffic
// checked every cycle against a transaction-level model of grant order, clipping and counters.
module tb_pixel_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] vp_x0, vp_y0, vp_x1, vp_y1;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [47:0] req_x, req_y;
  logic [71:0] req_color;
  logic        fb_valid, fb_ready, busy;
  logic [18:0] fb_addr;
  logic [23:0] fb_data;
  logic [15:0] clip_count;
  logic [31:0] write_count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          m_last;
  bit          m_fbv;
  logic [18:0] m_addr;
  logic [23:0] m_data;
  int          m_clip;
  logic [31:0] m_wc;

  typedef struct {
    int  x, y, vx0, vy0, vx1, vy1;
    bit  exp_keep;
    int  exp_addr;
  } vec_t;
  vec_t tbl[10];

  pixel_write_arbiter dut (
    .clk(clk), .rst(rst),
    .vp_x0(vp_x0), .vp_y0(vp_y0), .vp_x1(vp_x1), .vp_y1(vp_y1),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .clip_count(clip_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int color);
    req_x[i*16 +: 16]     = 16'(x);
    req_y[i*16 +: 16]     = 16'(y);
    req_color[i*24 +: 24] = 24'(color);
  endtask

  task automatic set_vp(input int x0, input int y0, input int x1, input int y1);
    vp_x0 = 16'(x0); vp_y0 = 16'(y0); vp_x1 = 16'(x1); vp_y1 = 16'(y1);
  endtask

  function automatic bit model_keep(input int x, input int y);
    return x >= int'(vp_x0) && x <= int'(vp_x1) && y >= int'(vp_y0) && y <= int'(vp_y1)
           && x < 640 && y < 480;
  endfunction

  task automatic model_reset();
    m_last = 2; m_fbv = 0; m_addr = '0; m_data = '0; m_clip = 0; m_wc = '0;
  endtask

  // One clock: compare all outputs against the model, then advance the model across the edge.
  task automatic tick();
    int g;
    int x, y;
    #1;
    g = -1;
    if (!m_fbv || fb_ready)
      for (int k = 1; k <= 3; k++) begin
        int i;
        i = (m_last + k) % 3;
        if (g < 0 && req_valid[i]) g = i;
      end
    chk("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("fb_valid", 64'(fb_valid), 64'(m_fbv));
    chk("fb_addr", 64'(fb_addr), 64'(m_addr));
    chk("fb_data", 64'(fb_data), 64'(m_data));
    chk("clip_count", 64'(clip_count), 64'(m_clip));
    chk("write_count", 64'(write_count), 64'(m_wc));
    chk("busy", 64'(busy), 64'(m_fbv || (req_valid != 3'b000)));
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (m_fbv && fb_ready) begin
        m_wc = m_wc + 32'd1;
        m_fbv = 0;
      end
      if (g >= 0) begin
        m_last = g;
        x = int'(req_x[g*16 +: 16]);
        y = int'(req_y[g*16 +: 16]);
        if (model_keep(x, y)) begin
          m_fbv  = 1;
          m_addr = 19'((y * 640 + x) % 524288);
          m_data = req_color[g*24 +: 24];
        end else if (m_clip < 65535) m_clip++;
      end
    end
    #1;
  endtask

  initial begin
    int exp_clip;
    tbl[0] = '{10, 10, 0, 0, 639, 479, 1, 6410};
    tbl[1] = '{4, 3, 0, 0, 4, 3, 1, 1924};
    tbl[2] = '{5, 3, 0, 0, 4, 3, 0, 0};
    tbl[3] = '{4, 4, 0, 0, 4, 3, 0, 0};
    tbl[4] = '{700, 0, 0, 0, 4, 3, 0, 0};
    tbl[5] = '{639, 479, 0, 0, 65535, 65535, 1, 307199};
    tbl[6] = '{640, 0, 0, 0, 65535, 65535, 0, 0};
    tbl[7] = '{0, 480, 0, 0, 65535, 65535, 0, 0};
    tbl[8] = '{7, 7, 10, 0, 5, 479, 0, 0};
    tbl[9] = '{3, 5, 3, 5, 3, 5, 1, 3203};

    rst = 1'b1; req_valid = '0; fb_ready = 1'b1;
    req_x = '0; req_y = '0; req_color = '0;
    set_vp(0, 0, 639, 479);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // reset then idle
    #1;
    chk("idle_fb_valid", 64'(fb_valid), 64'd0);
    chk("idle_req_ready", 64'(req_ready), 64'd0);
    chk("idle_clip", 64'(clip_count), 64'd0);
    chk("idle_wcount", 64'(write_count), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    tick();

    // single raster pixel
    set_pix(1, 10, 10, 24'hFF0000);
    req_valid = 3'b010;
    #1 chk("raster_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b000;
    chk("raster_fb_valid", 64'(fb_valid), 64'd1);
    chk("raster_addr", 64'(fb_addr), 64'd6410);
    chk("raster_data", 64'(fb_data), 64'hFF0000);
    tick();
    chk("raster_wcount", 64'(write_count), 64'd1);

    // round robin with all three requesters valid
    rst = 1'b1; tick(); rst = 1'b0;
    set_pix(0, 1, 0, 24'h000001);
    set_pix(1, 2, 0, 24'h000002);
    set_pix(2, 3, 0, 24'h000003);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr_grant", 64'(req_ready), 64'd1 << (c % 3));
      tick();
      chk("rr_fb_valid", 64'(fb_valid), 64'd1);
      chk("rr_addr", 64'(fb_addr), 64'((c % 3) + 1));
    end
    chk("rr_wcount", 64'(write_count), 64'd5);
    req_valid = 3'b000;
    tick();

    // back-pressure on a held pixel
    set_pix(0, 20, 1, 24'h123456);
    req_valid = 3'b001;
    tick();
    fb_ready = 1'b0;
    set_pix(1, 30, 2, 24'hABCDEF);
    req_valid = 3'b011;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_addr", 64'(fb_addr), 64'd660);
      chk("bp_data", 64'(fb_data), 64'h123456);
      tick();
    end
    fb_ready = 1'b1;
    req_valid = 3'b010;
    #1 chk("bp_release_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b000;
    chk("bp_reload_valid", 64'(fb_valid), 64'd1);
    chk("bp_reload_addr", 64'(fb_addr), 64'd1310);
    chk("bp_reload_data", 64'(fb_data), 64'hABCDEF);
    tick();

    // clip vector table on the simd port
    rst = 1'b1; tick(); rst = 1'b0;
    exp_clip = 0;
    foreach (tbl[i]) begin
      set_vp(tbl[i].vx0, tbl[i].vy0, tbl[i].vx1, tbl[i].vy1);
      set_pix(2, tbl[i].x, tbl[i].y, 24'hA00000 + i);
      req_valid = 3'b100;
      #1 chk("vec_ready", 64'(req_ready), 64'b100);
      tick();
      req_valid = 3'b000;
      chk("vec_keep", 64'(fb_valid), 64'(tbl[i].exp_keep));
      if (tbl[i].exp_keep) chk("vec_addr", 64'(fb_addr), 64'(tbl[i].exp_addr));
      if (!tbl[i].exp_keep) exp_clip++;
      chk("vec_clip", 64'(clip_count), 64'(exp_clip));
      tick();
    end

    // inverted viewport clips everything
    set_vp(10, 0, 5, 479);
    req_valid = 3'b111;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 3; i++) set_pix(i, $urandom_range(0, 12), $urandom_range(0, 20), $urandom);
      tick();
      exp_clip++;
      chk("inv_fb_valid", 64'(fb_valid), 64'd0);
      chk("inv_clip", 64'(clip_count), 64'(exp_clip));
    end
    req_valid = 3'b000;
    tick();

    // reset while a write is held
    set_vp(0, 0, 639, 479);
    set_pix(1, 5, 5, 24'h00FF00);
    req_valid = 3'b010;
    tick();
    fb_ready = 1'b0;
    req_valid = 3'b000;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_fb_valid", 64'(fb_valid), 64'd0);
    chk("rst_fb_addr", 64'(fb_addr), 64'd0);
    chk("rst_clip", 64'(clip_count), 64'd0);
    chk("rst_wcount", 64'(write_count), 64'd0);
    fb_ready = 1'b1;
    req_valid = 3'b111;
    #1 chk("rst_first_grant", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b000;
    tick();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0)
        set_vp($urandom_range(0, 60), $urandom_range(0, 60),
               $urandom_range(0, 700), $urandom_range(0, 520));
      req_valid = 3'($urandom);
      fb_ready  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) set_pix(i, $urandom_range(0, 700), $urandom_range(0, 520), $urandom);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    req_valid = 3'b000;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_write_arbiter.md
Name: pixel_write_arbiter

Overview:
Shares the single framebuffer write port between the pixel producers inside the command processor: clear unit, rasterizer and SIMD unit. Each cycle it selects one pending pixel by round-robin and clips it against the active viewport and the framebuffer bounds. Surviving pixels are converted to a linear address and presented on a registered, back-pressured write port. It replaces the ad-hoc arbiter_pixel_* path and provides clip and write counters for debug.

Parameters:
NREQ, 3, number of requesters; index 0 = clear, 1 = raster, 2 = simd.
COORD_W, 16, width of x/y coordinates (unsigned).
COLOR_W, 24, pixel colour width.
FB_WIDTH, 640, framebuffer width in pixels.
FB_HEIGHT, 480, framebuffer height in pixels.
ADDR_W, 19, framebuffer word-address width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
vp_x0  in  COORD_W  viewport left, inclusive
vp_y0  in  COORD_W  viewport top, inclusive
vp_x1  in  COORD_W  viewport right, inclusive
vp_y1  in  COORD_W  viewport bottom, inclusive
req_valid  in  NREQ  per-requester pixel valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_x  in  NREQ*COORD_W  packed x, requester i at bits [i*COORD_W +: COORD_W]
req_y  in  NREQ*COORD_W  packed y
req_color  in  NREQ*COLOR_W  packed colour
fb_valid  out  1  write request to framebuffer
fb_ready  in  1  framebuffer accepts write
fb_addr  out  ADDR_W  linear pixel address
fb_data  out  COLOR_W  pixel colour
busy  out  1  fb_valid or any req_valid high
clip_count  out  16  clipped pixels, saturating
write_count  out  32  pixels handed to framebuffer, wrapping

Behaviour:
- Reset (rst high at posedge):
  - fb_valid = 0, fb_addr = 0, fb_data = 0.
  - clip_count = 0, write_count = 0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
  - Reset mid-transaction drops the held pixel; no partial state survives.
- Slot free: can_accept = !fb_valid || fb_ready.
- Grant (combinational):
  - When can_accept, grant the first requester with req_valid, searching from pointer+1 modulo NREQ.
  - req_ready is asserted for that requester only. All other req_ready bits are 0.
  - When !can_accept, all req_ready bits are 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake: a transfer occurs when req_valid[g] && req_ready[g]. The pointer updates to g on that edge and is unchanged otherwise.
- Clip test on the granted pixel (x, y). A pixel is kept iff all of the following hold:
  - vp_x0 <= x <= vp_x1
  - vp_y0 <= y <= vp_y1
  - x < FB_WIDTH
  - y < FB_HEIGHT
  - An inverted viewport (x0 > x1 or y0 > y1) clips every pixel.
- Kept pixel: on the transfer edge, load fb_addr = y*FB_WIDTH + x (computed at full width, truncated to ADDR_W), fb_data = colour, fb_valid = 1. Latency is 1 cycle from handshake to fb_valid.
- Clipped pixel:
  - Still consumed (req_ready high).
  - Output register is not loaded. fb_valid becomes 0 if the current write drains this cycle, otherwise it holds.
  - clip_count increments, saturating at 0xFFFF.
- Output hold: while fb_valid && !fb_ready, fb_valid, fb_addr and fb_data are held stable.
- Drain and reload in the same cycle: when fb_valid && fb_ready coincide with a kept transfer, the register reloads with the new pixel and fb_valid stays 1. Full throughput is one pixel per cycle.
- write_count increments on each fb_valid && fb_ready and wraps at 2^32.
- Viewport inputs are sampled combinationally at the grant cycle. Changing them affects only subsequent grants, never the held pixel.
- busy = fb_valid || |req_valid.

Test Plan:
- Reset then idle: all req_valid = 0 -> fb_valid = 0, req_ready = 000, counts 0, busy = 0.
- Single raster pixel (10,10), colour 0xFF0000, viewport 0..639/0..479, fb_ready = 1 -> req_ready[1] pulses for 1 cycle; next cycle fb_valid = 1, fb_addr = 6410, fb_data = 0xFF0000; write_count = 1.
- All three requesters valid continuously, fb_ready = 1 -> grants follow order 0,1,2,0,1,2; one fb write per cycle.
- Back-pressure: fb_ready = 0 for 4 cycles with a held pixel -> fb_addr/fb_data stable, req_ready = 000 throughout; on fb_ready = 1 the next grant reloads in the same cycle.
- Viewport 0..4/0..3, simd pixels (4,3), (5,3), (4,4), (700,0) -> only (4,3) is written (fb_addr = 1924); clip_count = 3; all four are consumed.
- Inverted viewport x0 = 10, x1 = 5 -> every pixel is clipped and no fb_valid is raised. Assert rst while fb_valid is held -> fb_valid = 0 next cycle, counters = 0, requester 0 has first priority afterwards.
